imm_gen_pipe: RTL

//  Pipelined, parametrised immediate generator for the ID stage; successor to the combinational extender.

---
 rtl/imm_gen_pkg.sv | 33 +++
 rtl/imm_decode.sv | 66 ++++++
 rtl/imm_gen_pipe.sv | 124 ++++++++++++
 3 files changed

// File: rtl/imm_gen_pkg.sv
// Shared definitions for the pipelined immediate generator: RV32I/RV64I base
// opcodes, the 3-bit format encoding and the XLEN legality check.
package imm_gen_pkg;

  typedef enum logic [2:0] {
    FMT_R       = 3'd0,
    FMT_I       = 3'd1,
    FMT_S       = 3'd2,
    FMT_B       = 3'd3,
    FMT_U       = 3'd4,
    FMT_J       = 3'd5,
    FMT_SHAMT   = 3'd6,
    FMT_ILLEGAL = 3'd7
  } fmt_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;

  function automatic bit xlen_legal(input int xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder: builds a 32-bit immediate per base format,
// then sign-extends it (from bit 31) to XLEN.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst_i,
  output logic [XLEN-1:0] imm_o,
  output fmt_t            fmt_o
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        sign;
  logic        shamt_hi;
  logic [31:0] imm32;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];
  assign sign   = inst_i[31];
  // RV64 shift amounts are 6 bits wide; RV32 ones only 5
  assign shamt_hi = (XLEN == 64) ? inst_i[25] : 1'b0;

  always_comb begin
    imm32 = '0;
    fmt_o = FMT_ILLEGAL;
    case (opcode)
      OPC_OP: fmt_o = FMT_R;
      OPC_OP_IMM: begin
        if (funct3 == F3_SLL || funct3 == F3_SR) begin
          fmt_o = FMT_SHAMT;
          imm32 = {26'b0, shamt_hi, inst_i[24:20]};
        end else begin
          fmt_o = FMT_I;
          imm32 = {{20{sign}}, inst_i[31:20]};
        end
      end
      OPC_LOAD, OPC_JALR: begin
        fmt_o = FMT_I;
        imm32 = {{20{sign}}, inst_i[31:20]};
      end
      OPC_STORE: begin
        fmt_o = FMT_S;
        imm32 = {{20{sign}}, inst_i[31:25], inst_i[11:7]};
      end
      OPC_BRANCH: begin
        fmt_o = FMT_B;
        imm32 = {{19{sign}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt_o = FMT_U;
        imm32 = {inst_i[31:12], 12'b0};
      end
      OPC_JAL: begin
        fmt_o = FMT_J;
        imm32 = {{11{sign}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
      end
      default: ;
    endcase
  end

  // Replicate from bit 30 upward so XLEN=32 never needs a zero-width replication
  assign imm_o = {{(XLEN-31){imm32[31]}}, imm32[30:0]};

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decode at accept into a 2-entry FIFO skid
// buffer (head drives outputs), plus a sticky error flag and saturating counter.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int TAG_W     = 5,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [31:0]          inst_i,
  input  logic [TAG_W-1:0]     tag_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [XLEN-1:0]      imm_o,
  output logic [2:0]           fmt_o,
  output logic [TAG_W-1:0]     tag_o,
  input  logic                 clr_err_i,
  output logic                 err_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  localparam int DEPTH = 2;

  if (!xlen_legal(XLEN)) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    fmt_t             fmt;
    logic [TAG_W-1:0] tag;
  } beat_t;

  logic [XLEN-1:0]      dec_imm;
  fmt_t                 dec_fmt;
  beat_t                new_beat;
  beat_t                ent_q [DEPTH];
  beat_t                ent_d [DEPTH];
  logic [1:0]           cnt_q, cnt_d;
  logic                 ready_q, ready_d;
  logic                 err_q, err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 push, pop, illegal_acc;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .inst_i (inst_i),
    .imm_o  (dec_imm),
    .fmt_o  (dec_fmt)
  );

  assign push        = valid_i & ready_q;
  assign pop         = (cnt_q != 2'd0) & ready_i;
  assign illegal_acc = push & (dec_fmt == FMT_ILLEGAL);

  always_comb begin
    new_beat.imm = dec_imm;
    new_beat.fmt = dec_fmt;
    new_beat.tag = tag_i;
    ent_d = ent_q;
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10: begin
        ent_d[cnt_q[0]] = new_beat;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        ent_d[0] = ent_q[1];
        cnt_d = cnt_q - 2'd1;
      end
      // push implies a free slot, so with a pop here exactly one entry was held
      2'b11: ent_d[0] = new_beat;
      default: ;
    endcase
    ready_d = (cnt_d != 2'd2);
  end

  always_comb begin
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    if (illegal_acc) begin
      err_d     = 1'b1;
      err_cnt_d = clr_err_i ? ERR_CNT_W'(1)
                : (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + 1'b1;
    end else if (clr_err_i) begin
      err_d     = 1'b0;
      err_cnt_d = '0;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
    always_ff @(posedge clk_i) begin
      if (!rst_i) ent_q[gi] <= '0;
      else        ent_q[gi] <= ent_d[gi];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_q     <= 2'd0;
      ready_q   <= 1'b1;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Masking with reset keeps a held beat from leaving in the cycle it is flushed
  assign valid_o   = (cnt_q != 2'd0) & rst_i;
  assign ready_o   = ready_q;
  assign imm_o     = ent_q[0].imm;
  assign fmt_o     = ent_q[0].fmt;
  assign tag_o     = ent_q[0].tag;
  assign err_o     = err_q;
  assign err_cnt_o = err_cnt_q;

endmodule
